// File: rtl/watch_ctrl.sv
// watch_ctrl: run controller for the 1/100 s stopwatch.
// Each button is synchronized and debounced. The IDLE/RUN/STOP/LAP state
// machine then steps on button presses. The hundredths-tick prescaler runs
// only in RUN and LAP.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RESET     in   asynchronous active-low reset
//   BTN_SS    in   start/stop button, asynchronous, active-high
//   BTN_LAP   in   lap/clear button, asynchronous, active-high
//   CNT_EN    out  one-cycle pulse: advance the counter by one hundredth
//   CNT_CLR   out  one-cycle pulse: clear the counter
//   DISP_HOLD out  level: freeze the display latch (LAP only)
//   RUNNING   out  level: high in RUN or LAP
//   STATE     out  current state: 00 IDLE, 01 RUN, 10 STOP, 11 LAP
//
// Handshake note: there is no valid/ready traffic here. Each press is a
// single-cycle event, and every output is a registered level or pulse.
module watch_ctrl #(
    parameter int TICK_DIV   = 400000,
    parameter int DEB_CYCLES = 400000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_SS,
    input  logic       BTN_LAP,
    output logic       CNT_EN,
    output logic       CNT_CLR,
    output logic       DISP_HOLD,
    output logic       RUNNING,
    output logic [1:0] STATE
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STOP = 2'b10,
        S_LAP  = 2'b11
    } state_t;

    // Index 0 is the start/stop channel; index 1 is the lap/clear channel.
    logic [1:0]    btn;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    level_q, level_d;
    logic [1:0]    press_q, press_d;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          en_d, clr_d;
    logic          ss_ev, lap_ev;

    assign btn   = {BTN_LAP, BTN_SS};
    assign STATE = state_q;

    // Debouncer. A mismatch cycle that would bring the count to DEB_CYCLES
    // accepts the new level and clears the count in the same cycle.
    // Only a rising accepted level produces a press event.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i]   = level_q[i];
            press_d[i]   = 1'b0;
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    level_d[i] = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // If both presses arrive in the same cycle, start/stop wins.
    assign ss_ev  = press_q[0];
    assign lap_ev = press_q[1] & ~press_q[0];

    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            S_IDLE: if (ss_ev) state_d = S_RUN;
            S_RUN: begin
                if (ss_ev)       state_d = S_STOP;
                else if (lap_ev) state_d = S_LAP;
            end
            S_LAP: begin
                if (ss_ev)       state_d = S_STOP;
                else if (lap_ev) state_d = S_RUN;
            end
            S_STOP: begin
                if (ss_ev) begin
                    state_d = S_RUN;
                end else if (lap_ev) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The prescaler counts on the current state. A wrap on the stop edge
    // still fires. STOP holds the partial tick so a resume continues it.
    always_comb begin
        presc_d = presc_q;
        en_d    = 1'b0;
        if (state_q == S_RUN || state_q == S_LAP) begin
            if (presc_q == PW'(TICK_DIV - 1)) begin
                presc_d = '0;
                en_d    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        if (state_d == S_IDLE) presc_d = '0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
            state_q   <= S_IDLE;
            presc_q   <= '0;
            CNT_EN    <= 1'b0;
            CNT_CLR   <= 1'b0;
            DISP_HOLD <= 1'b0;
            RUNNING   <= 1'b0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            for (int i = 0; i < 2; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q   <= state_d;
            presc_q   <= presc_d;
            CNT_EN    <= en_d;
            CNT_CLR   <= clr_d;
            DISP_HOLD <= (state_d == S_LAP);
            RUNNING   <= (state_d == S_RUN) || (state_d == S_LAP);
        end
    end

endmodule

// File: doc/watch_ctrl.md
# watch_ctrl

Button-driven run controller for the 1/100 s stopwatch datapath. It debounces a start/stop button and a lap/clear button, runs the IDLE/RUN/STOP/LAP state machine, and generates the hundredths-tick prescaler. Its outputs are a one-cycle count-enable pulse, a clear pulse and a display-hold level that drive the BCD counter and the seven-segment display latch.

## Interface
- TICK_DIV, default 400000: system clocks per count tick (10 ms at 40 MHz); minimum 2.
- DEB_CYCLES, default 400000: consecutive stable samples required to accept a button level change; minimum 1.
- CLK  in  1  system clock, 40 MHz, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- BTN_SS  in  1  start/stop button, asynchronous, active-high.
- BTN_LAP  in  1  lap/clear button, asynchronous, active-high.
- CNT_EN  out  1  one-cycle pulse: advance the counter by 1/100 s.
- CNT_CLR  out  1  one-cycle pulse: clear the counter to 00.00.
- DISP_HOLD  out  1  level: freeze the display latch; the counter keeps running.
- RUNNING  out  1  level: high in RUN or LAP.
- STATE  out  2  current state: 00 IDLE, 01 RUN, 10 STOP, 11 LAP.

## Operation
- **Synchronizer.** Each button passes through its own 2-FF synchronizer.
- **Debouncer (per button).**
  - Holds an accepted level, reset value 0.
  - Its counter, width clog2(DEB_CYCLES+1), clears whenever the synchronized input equals the accepted level.
  - Otherwise the counter increments. When it reaches DEB_CYCLES, the accepted level flips and the counter clears.
  - A 0→1 flip of the accepted level produces a one-cycle press event. Releases produce no event.
- **Event priority.** If both press events occur in the same cycle, the SS event is taken and the LAP event is discarded.
- **State machine.** States are encoded as on STATE; reset state is IDLE. Unlisted events leave the state unchanged.
  - IDLE + SS → RUN.
  - RUN + SS → STOP.
  - RUN + LAP → LAP.
  - LAP + LAP → RUN.
  - LAP + SS → STOP.
  - STOP + SS → RUN (resume; no clear).
  - STOP + LAP → IDLE, with CNT_CLR pulsed in the transition cycle.
  - IDLE + LAP is ignored: no state change and no CNT_CLR.
- **Prescaler.**
  - Width clog2(TICK_DIV). It counts 0..TICK_DIV-1 only while in RUN or LAP.
  - At TICK_DIV-1 it wraps to 0 and CNT_EN pulses.
  - In STOP it holds its value, so the partial tick is preserved across a resume.
  - It clears to 0 on entering IDLE and on reset.
- **Display hold.** DISP_HOLD = 1 only in LAP. In STOP it is 0: the display shows the stopped count directly.
- **Outputs.** All outputs are registered, with no combinational path from inputs to outputs.

## Timing
- **Reset values.** While RESET = 0: CNT_EN = 0, CNT_CLR = 0, DISP_HOLD = 0, RUNNING = 0, STATE = 00. All counters and accepted levels are cleared, with immediate effect and no clock required.
- **Reset release.** Operation starts on the first rising edge after RESET returns high.
- **Press latency.** The input is first sampled high at edge k and held steady. The press event is asserted in the cycle after edge k+1+DEB_CYCLES. STATE, RUNNING and DISP_HOLD update at the following edge.
- **Bounce rejection.** A glitch shorter than DEB_CYCLES synchronized cycles produces no event.
- **CNT_CLR.** Pulses for exactly one cycle, coincident with STATE changing to 00.
- **First tick after start.** On IDLE→RUN, the first CNT_EN pulse occurs TICK_DIV cycles after STATE becomes 01; subsequent pulses come every TICK_DIV cycles.
- **Mode changes do not disturb the tick.** RUN↔LAP transitions do not reset the prescaler or disturb the tick period.
- **Stop and resume.** On RUN→STOP, no CNT_EN is issued from the cycle STATE becomes 10. If a wrap coincides with the stop edge, that pulse is still issued. On STOP→RUN, counting continues from the held prescaler value.
- **Reset mid-operation.** Asserting reset mid-run aborts immediately to IDLE; no CNT_CLR pulse is produced.

## Test plan
All scenarios use TICK_DIV = 4 and DEB_CYCLES = 3.
- **Reset.** Drive RESET = 0 mid-cycle while in RUN → all outputs go 0 and STATE = 00 asynchronously. After release, 20 cycles with buttons low → no CNT_EN.
- **Start and tick.** Hold BTN_SS high for 10 cycles from IDLE → STATE = 01 exactly 5 cycles after the first high sample. CNT_EN pulses at 4, 8 and 12 cycles after that. Exactly one event results.
- **Bounce rejection.** Toggle BTN_SS 1,0,1,0 on consecutive cycles, then hold it 0 → STATE stays 00 and no CNT_EN.
- **Lap.**
  - In RUN, press BTN_LAP → STATE = 11, DISP_HOLD = 1, and CNT_EN keeps a 4-cycle period without phase shift.
  - Press BTN_LAP again → STATE = 01, DISP_HOLD = 0.
- **Stop, resume and clear.**
  - Press BTN_SS when the prescaler is at 2 → STATE = 10 and CNT_EN stops.
  - Press BTN_SS again → the next CNT_EN comes 2 cycles after STATE = 01.
  - Stop again, then press BTN_LAP → one-cycle CNT_CLR with STATE = 00. The next start gives its first tick after 4 cycles.
- **Simultaneous events.** Assert both buttons on the same edge in RUN → STATE = 10 only, and DISP_HOLD stays 0. In IDLE, BTN_LAP alone → no change and no CNT_CLR.
